// File: rtl/xgmii_rr_arb_if.sv
// Source-side FIFO handshake bundle for the four-port XGMII frame arbiter.
// The master modport belongs to the per-port FIFOs and the slave modport to the arbiter.
interface xgmii_rr_arb_if;
   logic [3:0]   in_frame_rdy;
   logic [3:0]   in_empty;
   logic [31:0]  in_rxc;
   logic [255:0] in_rxd;
   logic [3:0]   in_rd_en;

   modport master (
      output in_frame_rdy,
      output in_empty,
      output in_rxc,
      output in_rxd,
      input  in_rd_en
   );

   modport slave (
      input  in_frame_rdy,
      input  in_empty,
      input  in_rxc,
      input  in_rxd,
      output in_rd_en
   );
endinterface

// File: rtl/xgmii_rr_arb.sv
// Four-port XGMII frame arbiter: forwards one whole frame at a time from first-word-fall-through FIFOs.
// Define XGMII_ARB_PRIO0_EN to give port 0 strict priority over round-robin ports 1..3.
module xgmii_rr_arb #(
   parameter int IFG_WORDS = 1
) (
   input  logic             xgmii_clk,
   input  logic             sys_rst,
   xgmii_rr_arb_if.slave    bus,
   output logic [7:0]       xgmii_rxc,
   output logic [63:0]      xgmii_rxd,
   output logic [1:0]       grant,
   output logic             busy,
   output logic [7:0]       underrun_cnt,
   output logic [15:0]      frame_cnt
);

   localparam logic [7:0]  IDLE_C   = 8'hff;
   localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
   localparam logic [3:0]  IFG_LAST = 4'(IFG_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_IFG
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        data_seen;
   logic [3:0]  ifg_cnt;

   logic [1:0]  pick;
   logic        pick_valid;
   logic [1:0]  cand;
   logic [7:0]  head_rxc;
   logic [63:0] head_rxd;
   logic        head_empty;
   logic        pop;
   logic        term;

   assign head_rxc   = bus.in_rxc[{grant, 3'b000} +: 8];
   assign head_rxd   = bus.in_rxd[{grant, 6'b000000} +: 64];
   assign head_empty = bus.in_empty[grant];
   assign pop        = (state == S_SEND) && !head_empty;
   // Leaving SEND on the terminate edge is what stops any pop beyond the terminate word.
   assign term       = pop && data_seen && (head_rxc == IDLE_C);

   // Search upward from the last granted port so every ready port is served in turn.
   always_comb begin
      pick       = grant;
      pick_valid = 1'b0;
      cand       = grant;
`ifdef XGMII_ARB_PRIO0_EN
      if (bus.in_frame_rdy[0]) begin
         pick       = 2'd0;
         pick_valid = 1'b1;
      end else begin
         for (int i = 1; i <= 4; i++) begin
            cand = grant + 2'(i);
            if (!pick_valid && (cand != 2'd0) && bus.in_frame_rdy[cand]) begin
               pick       = cand;
               pick_valid = 1'b1;
            end
         end
      end
`else
      for (int i = 1; i <= 4; i++) begin
         cand = grant + 2'(i);
         if (!pick_valid && bus.in_frame_rdy[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (pick_valid) begin
               next_state = S_SEND;
            end
         end
         S_SEND: begin
            if (term) begin
               next_state = S_IFG;
            end
         end
         S_IFG: begin
            if (ifg_cnt == IFG_LAST) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Reset blocks the pop strobe immediately so a reset mid-frame never consumes a word.
   always_comb begin
      busy        = (state == S_SEND) || (state == S_IFG);
      bus.in_rd_en = 4'b0000;
      if (pop && !sys_rst) begin
         bus.in_rd_en[grant] = 1'b1;
      end
   end

   always_ff @(posedge xgmii_clk) begin
      if (sys_rst) begin
         grant        <= 2'd3;
         data_seen    <= 1'b0;
         ifg_cnt      <= 4'd0;
         xgmii_rxc    <= IDLE_C;
         xgmii_rxd    <= IDLE_D;
         underrun_cnt <= 8'd0;
         frame_cnt    <= 16'd0;
      end else begin
         if (pop) begin
            xgmii_rxc <= head_rxc;
            xgmii_rxd <= head_rxd;
         end else begin
            xgmii_rxc <= IDLE_C;
            xgmii_rxd <= IDLE_D;
         end

         if ((state == S_IDLE) && pick_valid) begin
            grant     <= pick;
            data_seen <= 1'b0;
         end else if (pop && (head_rxc != IDLE_C)) begin
            data_seen <= 1'b1;
         end

         if (state == S_IFG) begin
            ifg_cnt <= ifg_cnt + 4'd1;
         end else begin
            ifg_cnt <= 4'd0;
         end

         // A starved source stalls the frame indefinitely; only the count records it.
         if ((state == S_SEND) && head_empty && (underrun_cnt != 8'hff)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
         end

         if (term) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule
